// File: rtl/tx_switch_sequencer.sv
// Switch/gate sequencer: walks lane-0, lane-1 and gate control pulses with
// programmable gap/settle waits, capturing time stamps at key stages.
module tx_switch_sequencer #(
  parameter int unsigned TIMESTAMP_WIDTH = 64,
  parameter int unsigned DLY_WIDTH       = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DLY_WIDTH-1:0]       cfg_gap,
  input  logic [DLY_WIDTH-1:0]       cfg_settle,
  input  logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
  output logic                       rst_count,
  output logic                       lane0_on,
  output logic                       lane0_done,
  output logic                       lane1_on,
  output logic                       lane1_done,
  output logic                       gate_ctrl,
  output logic                       tready0_en,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic [TIMESTAMP_WIDTH-1:0] ts_l0_on,
  output logic [TIMESTAMP_WIDTH-1:0] ts_l1_done,
  output logic [TIMESTAMP_WIDTH-1:0] ts_gate,
  output logic [15:0]                run_count
);

  typedef enum logic [3:0] {
    StIdle, StRst, StGap0, StL0On, StSettle0, StL0Done, StGap1,
    StL1On, StSettle1, StL1Done, StGap2, StGate, StDone
  } state_e;

  state_e                     state_q, state_d;
  logic [DLY_WIDTH-1:0]       gap_q, settle_q, cnt_q;
  logic [DLY_WIDTH-1:0]       gap_load, settle_load;
  logic [TIMESTAMP_WIDTH-1:0] ts_l0_on_q, ts_l1_done_q, ts_gate_q;
  logic [15:0]                run_count_q;
  logic                       tready0_en_q, aborted_q;
  logic                       cnt_zero, accept, abort_run;
  logic                       gap_next, settle_next, wait_entry;

  assign cnt_zero    = (cnt_q == '0);
  assign accept      = (state_q == StIdle) && start && !abort;
  assign abort_run   = (state_q != StIdle) && abort;
  // A programmed delay of 0 behaves as 1, so both 0 and 1 load a count of 0.
  assign gap_load    = (gap_q == '0) ? '0 : gap_q - DLY_WIDTH'(1);
  assign settle_load = (settle_q == '0) ? '0 : settle_q - DLY_WIDTH'(1);
  assign gap_next    = state_d inside {StGap0, StGap1, StGap2};
  assign settle_next = state_d inside {StSettle0, StSettle1};
  assign wait_entry  = (state_d != state_q) && (gap_next || settle_next);

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StRst;
      StRst:     state_d = StGap0;
      StGap0:    if (cnt_zero) state_d = StL0On;
      StL0On:    state_d = StSettle0;
      StSettle0: if (cnt_zero) state_d = StL0Done;
      StL0Done:  state_d = StGap1;
      StGap1:    if (cnt_zero) state_d = StL1On;
      StL1On:    state_d = StSettle1;
      StSettle1: if (cnt_zero) state_d = StL1Done;
      StL1Done:  state_d = StGap2;
      StGap2:    if (cnt_zero) state_d = StGate;
      StGate:    state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (abort_run) state_d = StIdle;
  end

  always_comb begin
    rst_count  = 1'b0;
    lane0_on   = 1'b0;
    lane0_done = 1'b0;
    lane1_on   = 1'b0;
    lane1_done = 1'b0;
    gate_ctrl  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StRst:    rst_count  = 1'b1;
      StL0On:   lane0_on   = 1'b1;
      StL0Done: lane0_done = 1'b1;
      StL1On:   lane1_on   = 1'b1;
      StL1Done: lane1_done = 1'b1;
      StGate:   gate_ctrl  = 1'b1;
      StDone:   done       = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      gap_q        <= '0;
      settle_q     <= '0;
      cnt_q        <= '0;
      ts_l0_on_q   <= '0;
      ts_l1_done_q <= '0;
      ts_gate_q    <= '0;
      run_count_q  <= '0;
      tready0_en_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      aborted_q <= abort_run;
      if (accept) begin
        gap_q    <= cfg_gap;
        settle_q <= cfg_settle;
      end
      if (wait_entry)     cnt_q <= gap_next ? gap_load : settle_load;
      else if (!cnt_zero) cnt_q <= cnt_q - DLY_WIDTH'(1);
      if (state_q == StL0On)   ts_l0_on_q   <= stamp_counter;
      if (state_q == StL1Done) ts_l1_done_q <= stamp_counter;
      if (state_q == StGate)   ts_gate_q    <= stamp_counter;
      if (state_q == StDone)   run_count_q  <= run_count_q + 16'd1;
      // Set on GATE entry so the sink sees ready within the GATE cycle itself.
      if (accept || abort)                          tready0_en_q <= 1'b0;
      else if (state_d == StGate && state_q != StGate) tready0_en_q <= 1'b1;
    end
  end

  assign ts_l0_on   = ts_l0_on_q;
  assign ts_l1_done = ts_l1_done_q;
  assign ts_gate    = ts_gate_q;
  assign run_count  = run_count_q;
  assign tready0_en = tready0_en_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_tx_switch_sequencer.sv
// Scoreboard bench for tx_switch_sequencer: a schedule model predicts every
// pulse and busy window; a monitor pops and compares as the DUT emits them.
module tb_tx_switch_sequencer;
  localparam int TW = 64;
  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] cfg_gap = '0;
  logic [DW-1:0] cfg_settle = '0;
  logic [TW-1:0] stamp_counter = '0;
  logic          rst_count, lane0_on, lane0_done, lane1_on, lane1_done, gate_ctrl;
  logic          tready0_en, busy, done, aborted;
  logic [TW-1:0] ts_l0_on, ts_l1_done, ts_gate;
  logic [15:0]   run_count;

  tx_switch_sequencer #(.TIMESTAMP_WIDTH(TW), .DLY_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .cfg_gap(cfg_gap), .cfg_settle(cfg_settle), .stamp_counter(stamp_counter),
    .rst_count(rst_count), .lane0_on(lane0_on), .lane0_done(lane0_done),
    .lane1_on(lane1_on), .lane1_done(lane1_done), .gate_ctrl(gate_ctrl),
    .tready0_en(tready0_en), .busy(busy), .done(done), .aborted(aborted),
    .ts_l0_on(ts_l0_on), .ts_l1_done(ts_l1_done), .ts_gate(ts_gate),
    .run_count(run_count)
  );

  always #5 aclk = ~aclk;

  // Cycle n is the interval after the edge that makes cyc == n.
  longint cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;
  always @(negedge aclk) stamp_counter <= TW'(cyc);

  typedef struct {
    int          kind;  // 0 rst,1 l0_on,2 l0_done,3 l1_on,4 l1_done,5 gate,6 done,7 aborted
    longint      cyc;
    logic [15:0] rc;
    logic [63:0] t0, t1, t2;
  } ev_t;

  ev_t         exp_q[$];
  int          blen_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;

  longint      busy_end = -10;
  longint      cur_r = 0;
  longint      cur_ev[7];
  logic [63:0] m_t0 = '0, m_t1 = '0, m_t2 = '0;
  logic [15:0] m_rc = '0;
  bit          run_open = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_ev(input int k, input longint t, input logic [15:0] rc,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] c);
    ev_t e;
    e.kind = k; e.cyc = t; e.rc = rc; e.t0 = a; e.t1 = b; e.t2 = c;
    exp_q.push_back(e);
  endfunction

  function automatic void purge(input longint c);
    ev_t keep[$];
    foreach (exp_q[i]) if (exp_q[i].cyc <= c) keep.push_back(exp_q[i]);
    exp_q = keep;
  endfunction

  // Fold whatever part of the current run happened by cycle c into the model.
  function automatic void commit_upto(input longint c);
    if (cur_ev[1] <= c) m_t0 = 64'(cur_ev[1]);
    if (cur_ev[4] <= c) m_t1 = 64'(cur_ev[4]);
    if (cur_ev[5] <= c) m_t2 = 64'(cur_ev[5]);
    if (cur_ev[6] <= c) m_rc = m_rc + 16'd1;
    run_open = 1'b0;
  endfunction

  // Predict the effect of the edge that ends cycle c.
  function automatic void model_edge(input longint c, input logic st, input logic ab,
                                     input logic rn, input logic [15:0] g,
                                     input logic [15:0] s);
    bit     act;
    longint eg, es;
    act = (c <= busy_end);
    if (!rn) begin
      if (act) begin
        purge(c);
        blen_q[blen_q.size()-1] = int'(c - cur_r + 1);
        busy_end = c;
      end
      run_open = 1'b0;
      m_t0 = '0; m_t1 = '0; m_t2 = '0; m_rc = '0;
    end else if (act) begin
      if (ab) begin
        if (run_open) commit_upto(c);
        purge(c);
        push_ev(7, c + 1, m_rc, m_t0, m_t1, m_t2);
        blen_q[blen_q.size()-1] = int'(c - cur_r + 1);
        busy_end = c;
      end
    end else if (st && !ab) begin
      if (run_open) commit_upto(cur_ev[6]);
      eg = (g == 0) ? 1 : longint'(g);
      es = (s == 0) ? 1 : longint'(s);
      cur_r     = c + 1;
      cur_ev[0] = cur_r;
      cur_ev[1] = cur_ev[0] + eg + 1;
      cur_ev[2] = cur_ev[1] + es + 1;
      cur_ev[3] = cur_ev[2] + eg + 1;
      cur_ev[4] = cur_ev[3] + es + 1;
      cur_ev[5] = cur_ev[4] + eg + 1;
      cur_ev[6] = cur_ev[5] + 1;
      for (int k = 0; k < 7; k++)
        push_ev(k, cur_ev[k], m_rc, 64'(cur_ev[1]), 64'(cur_ev[4]), 64'(cur_ev[5]));
      blen_q.push_back(int'(3 * eg + 2 * es + 7));
      busy_end = cur_r + 3 * eg + 2 * es + 6;
      run_open = 1'b1;
    end
  endfunction

  task automatic drive(input logic st, input logic ab, input logic rn,
                       input logic [15:0] g, input logic [15:0] s);
    start = st; abort = ab; aresetn = rn; cfg_gap = g; cfg_settle = s;
    model_edge(cyc, st, ab, rn, g, s);
    @(negedge aclk);
  endtask

  task automatic idle_until(input longint t);
    while (cyc < t) drive(1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({rst_count, lane0_on, lane0_done, lane1_on, lane1_done,
                             gate_ctrl, done, aborted, busy, tready0_en}), 64'd0);
    chk({tag, "_ts_l0_on"}, ts_l0_on, 64'd0);
    chk({tag, "_ts_l1_done"}, ts_l1_done, 64'd0);
    chk({tag, "_ts_gate"}, ts_gate, 64'd0);
    chk({tag, "_run_count"}, 64'(run_count), 64'd0);
  endtask

  // Monitor: every pulse pops the next expected event; busy windows are timed.
  initial begin
    ev_t        e;
    logic [7:0] p;
    int         run_len;
    bit         busy_prev;
    run_len = 0;
    busy_prev = 1'b0;
    wait (mon_en);
    forever begin
      @(posedge aclk);
      #1;
      p = {aborted, done, gate_ctrl, lane1_done, lane1_on, lane0_done, lane0_on, rst_count};
      for (int k = 0; k < 8; k++) begin
        if (p[k] === 1'b1) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none required", k, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", 64'(k), 64'(e.kind));
            chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
            case (e.kind)
              0: begin
                chk("rst_tready0_en", 64'(tready0_en), 64'd0);
                chk("rst_run_count", 64'(run_count), 64'(e.rc));
              end
              5: chk("gate_tready0_en", 64'(tready0_en), 64'd1);
              6, 7: begin
                chk(e.kind == 6 ? "done_tready0_en" : "abort_tready0_en",
                    64'(tready0_en), e.kind == 6 ? 64'd1 : 64'd0);
                chk("run_count", 64'(run_count), 64'(e.rc));
                chk("ts_l0_on", ts_l0_on, e.t0);
                chk("ts_l1_done", ts_l1_done, e.t1);
                chk("ts_gate", ts_gate, e.t2);
              end
              default: ;
            endcase
          end
        end
      end
      if (busy === 1'b1) begin
        run_len++;
      end else if (busy_prev) begin
        if (blen_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_busy: window of %0d cycles, none required", run_len);
        end else begin
          chk("busy_len", 64'(run_len), 64'(blen_q.pop_front()));
        end
        run_len = 0;
      end
      busy_prev = (busy === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        st, ab;
    logic [15:0] g, s;
    @(negedge aclk);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    check_zero("por");
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 16'd2, 16'd3);

    // Nominal run with start held and config churning mid-run.
    drive(1'b1, 1'b0, 1'b1, 16'd2, 16'd3);
    while (cyc <= busy_end) drive(1'b1, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
    drive(1'b0, 1'b0, 1'b1, 16'd2, 16'd3);

    // Zero delays.
    drive(1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
    idle_until(busy_end + 2);

    // Abort inside SETTLE0, then abort and start+abort while idle.
    drive(1'b1, 1'b0, 1'b1, 16'd2, 16'd3);
    idle_until(cur_ev[1] + 2);
    drive(1'b0, 1'b1, 1'b1, 16'd2, 16'd3);
    drive(1'b0, 1'b1, 1'b1, 16'd2, 16'd3);
    drive(1'b1, 1'b1, 1'b1, 16'd2, 16'd3);
    idle_until(cyc + 3);

    // Reset in the first GAP1 cycle.
    drive(1'b1, 1'b0, 1'b1, 16'd2, 16'd3);
    idle_until(cur_ev[2] + 1);
    drive(1'b0, 1'b0, 1'b0, 16'd2, 16'd3);
    check_zero("midrun_reset");
    drive(1'b0, 1'b0, 1'b0, 16'd2, 16'd3);
    idle_until(cyc + 2);

    // run_count wrap from 0xFFFF.
    dut.run_count_q = 16'hFFFF;
    m_rc = 16'hFFFF;
    drive(1'b1, 1'b0, 1'b1, 16'd1, 16'd1);
    idle_until(busy_end + 2);
    drive(1'b1, 1'b0, 1'b1, 16'd0, 16'd1);
    idle_until(busy_end + 2);

    for (int i = 0; i < 1500; i++) begin
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 39) == 0);
      g  = 16'($urandom_range(0, 5));
      s  = 16'($urandom_range(0, 5));
      drive(st, ab, 1'b1, g, s);
    end
    idle_until(busy_end + 3);

    if (run_open) commit_upto(cur_ev[6]);
    chk("final_run_count", 64'(run_count), 64'(m_rc));
    chk("final_ts_l0_on", ts_l0_on, m_t0);
    chk("final_ts_l1_done", ts_l1_done, m_t1);
    chk("final_ts_gate", ts_gate, m_t2);
    chk("events_drained", 64'(exp_q.size()), 64'd0);
    chk("busy_windows_drained", 64'(blen_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
